ex_issue_arbiter: RTL and testbench
===================================

Name: ex_issue_arbiter

Overview:
- Shares the single execution unit between two reservation stations, rs0 and rs1.
- Each station presents a stream of 20-bit uops for one instruction.
- The arbiter selects between the stations round-robin, then locks onto the granted station until that station's last uop issues, so uop sequences never interleave.
- Issue goes through a registered output stage with backpressure.
- A lock-timeout watchdog recovers from a station that stalls mid-instruction.

Parameters:
- NOP, 20'b0000_0000_1111_00_000_000: uop driven on ex_uop when no uop is issued.
- LOCK_TIMEOUT, 64: idle cycles tolerated in a lock state before forced release (legal range 1..255).

Ports:
- clk  in  1  clock.
- a_rst  in  1  asynchronous active-low reset.
- rs0_valid  in  1  rs0 presents a uop.
- rs0_uop  in  20  rs0 uop.
- rs0_last  in  1  presented uop is the final uop of its instruction.
- rs0_pc  in  16  instruction PC.
- rs0_data  in  16  operand/temp data.
- rs0_ack  out  1  rs0 uop consumed this cycle.
- rs1_valid, rs1_uop, rs1_last, rs1_pc, rs1_data, rs1_ack: same as rs0, for station 1.
- ex_ready  in  1  execution unit accepts the output stage this cycle.
- ex_valid  out  1  output stage holds a uop.
- ex_uop  out  20  issued uop.
- ex_pc  out  16  issued PC.
- ex_data  out  16  issued data.
- ex_src  out  1  source station of the issued uop (0/1).
- err_timeout  out  1  sticky lock-timeout flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (async, a_rst low, any time including mid-lock):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - ex_valid=0, ex_uop=NOP, ex_pc=0, ex_data=0, ex_src=0, err_timeout=0.
  - rs0_ack and rs1_ack are 0 while a_rst is low.
- accept = ex_ready | ~ex_valid (output stage free or draining).
- Grant selection (combinational):
  - IDLE: if both stations are valid, grant rr_ptr; if only one is valid, grant it; if neither, no grant.
  - LOCK0: candidate is rs0 only. LOCK1: candidate is rs1 only.
- Acknowledge: rsN_ack = accept & granted(N) & rsN_valid, combinational in the same cycle. At most one ack per cycle. uop content is never inspected.
- Output stage, updated on the clock edge when accept=1:
  - With an ack: load the acked station's uop, pc, data and index into ex_uop, ex_pc, ex_data, ex_src; ex_valid=1.
  - Without an ack: ex_valid=0, ex_uop=NOP; ex_pc, ex_data and ex_src hold their values.
  - When accept=0 all outputs hold.
  - Latency: ack to ex_valid is 1 cycle. Sustained throughput is 1 uop/cycle while ex_ready=1.
- State transitions, on an ack from station N:
  - rsN_last=0: next state is LOCKN.
  - rsN_last=1: next state is IDLE and rr_ptr <= ~N.
  - A single-uop instruction (last=1 issued in IDLE) therefore never enters a lock state.
- Timeout counter (8-bit):
  - Cleared on any ack and in IDLE.
  - In LOCKN, increments each cycle that rsN_valid=0. Cycles stalled by ex_ready=0 with rsN_valid=1 do not count.
  - When counter == LOCK_TIMEOUT-1 and another idle cycle occurs: state <= IDLE, rr_ptr <= ~N, err_timeout <= 1, counter <= 0.
- err_timeout is sticky. err_clr=1 clears it; if a set and err_clr occur in the same cycle, set wins.
- Simultaneous valid from both stations in IDLE: only the rr_ptr station is acked; the other station waits at least until the lock releases.
- The locked station may deassert valid between uops; the lock persists until last issues or the timeout fires.

Test Plan:
- Reset mid-lock: issue rs0 uop A (last=0), assert a_rst low -> ex_valid=0, ex_uop=NOP, err_timeout=0; after release, rs1 valid alone is acked first.
- Round robin: both valid with single-uop instructions (last=1), ex_ready=1 -> acks alternate rs0, rs1, rs0, rs1; ex_src follows 0,1,0,1 one cycle later.
- Lock: rs0 sends 3 uops (last on the 3rd) while rs1 is valid throughout -> rs1_ack=0 for those 3 cycles; rs1 is acked on the 4th cycle; ex_uop sequence is rs0 u0, u1, u2, then rs1.
- Backpressure: ex_ready=0 for 5 cycles with ex_valid=1 -> no acks, ex_uop/ex_pc/ex_data stable; raising ex_ready resumes issue with no uop lost or duplicated.
- Timeout: LOCK_TIMEOUT=4; rs0 issues last=0 then drops valid -> after 4 idle cycles state is IDLE and err_timeout=1; rs1 is then granted; err_clr pulse -> err_timeout=0.
- Set/clear collision: err_clr held high on the timeout cycle -> err_timeout=1.

Source files
------------

// File: rtl/ex_issue_arbiter.sv
// ex_issue_arbiter
//
// Shares one execution unit between two reservation stations (rs0, rs1).
// Selection is round-robin between whole instructions. Once a station is
// granted a uop that is not the last of its instruction, the arbiter locks
// onto that station until its last uop issues, so the uop streams of the two
// stations never interleave. Issued uops pass through a single registered
// output stage with ready/valid backpressure. A watchdog releases a lock
// whose owner has stopped presenting uops for LOCK_TIMEOUT cycles and raises
// a sticky error flag.
//
// State table:
//   state | meaning
//   IDLE  | no instruction in flight; round-robin choice between stations
//   LOCK0 | rs0 is mid-instruction; only rs0 may issue
//   LOCK1 | rs1 is mid-instruction; only rs1 may issue
//
// Ports:
//   clk          clock
//   a_rst        asynchronous reset, active low
//   rsN_valid    station N presents a uop
//   rsN_uop      station N uop (never inspected, only forwarded)
//   rsN_last     presented uop is the final uop of its instruction
//   rsN_pc       instruction PC
//   rsN_data     operand/temp data
//   rsN_ack      station N uop consumed this cycle (combinational)
//   ex_ready     execution unit accepts the output stage this cycle
//   ex_valid     output stage holds a uop
//   ex_uop       issued uop (NOP when nothing is issued)
//   ex_pc        issued PC
//   ex_data      issued data
//   ex_src       station the issued uop came from
//   err_timeout  sticky lock-timeout flag
//   err_clr      clears err_timeout (a simultaneous set wins)
//
// LOCK_TIMEOUT is meaningful in the range 1..255.

module ex_issue_arbiter #(
    parameter logic [19:0] NOP          = 20'b0000_0000_1111_00_000_000,
    parameter int          LOCK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        a_rst,

    input  logic        rs0_valid,
    input  logic [19:0] rs0_uop,
    input  logic        rs0_last,
    input  logic [15:0] rs0_pc,
    input  logic [15:0] rs0_data,
    output logic        rs0_ack,

    input  logic        rs1_valid,
    input  logic [19:0] rs1_uop,
    input  logic        rs1_last,
    input  logic [15:0] rs1_pc,
    input  logic [15:0] rs1_data,
    output logic        rs1_ack,

    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [19:0] ex_uop,
    output logic [15:0] ex_pc,
    output logic [15:0] ex_data,
    output logic        ex_src,

    output logic        err_timeout,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    // Counter value on which the next idle cycle fires the watchdog.
    localparam logic [7:0] TO_LAST = 8'(LOCK_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       rr_ptr_nxt;
    logic [7:0] to_cnt;
    logic [7:0] to_cnt_nxt;

    logic       accept;
    logic       grant0;
    logic       grant1;
    logic       any_ack;
    logic       lock_idle;
    logic       timeout_fire;

    // The output stage can take a new uop when it is empty or being drained.
    assign accept = ex_ready | ~ex_valid;

    assign any_ack = rs0_ack | rs1_ack;

    // The lock owner presents nothing this cycle. An ack implies the owner is
    // valid, so lock_idle and an ack are mutually exclusive.
    assign lock_idle = ((state == LOCK0) & ~rs0_valid) |
                       ((state == LOCK1) & ~rs1_valid);

    assign timeout_fire = lock_idle & (to_cnt == TO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            to_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;

        unique case (state)
            IDLE: begin
                if (rs0_ack) begin
                    if (rs0_last) begin
                        rr_ptr_nxt = 1'b1;
                    end else begin
                        state_nxt = LOCK0;
                    end
                end else if (rs1_ack) begin
                    if (rs1_last) begin
                        rr_ptr_nxt = 1'b0;
                    end else begin
                        state_nxt = LOCK1;
                    end
                end
            end
            LOCK0: begin
                if ((rs0_ack & rs0_last) | timeout_fire) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = 1'b1;
                end
            end
            LOCK1: begin
                if ((rs1_ack & rs1_last) | timeout_fire) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Watchdog counter: only counts owner-idle cycles; cycles stalled by the
    // execution unit while the owner is valid leave it untouched.
    always_comb begin
        to_cnt_nxt = to_cnt;
        if ((state == IDLE) | any_ack | timeout_fire) begin
            to_cnt_nxt = 8'd0;
        end else if (lock_idle) begin
            to_cnt_nxt = to_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: grant and acknowledge
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (state)
            IDLE: begin
                grant0 = rs0_valid & (~rs1_valid | ~rr_ptr);
                grant1 = rs1_valid & (~rs0_valid |  rr_ptr);
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase

        // a_rst gating keeps the acks quiet while the block is held in reset,
        // when the empty output stage would otherwise make accept true.
        rs0_ack = a_rst & accept & grant0 & rs0_valid;
        rs1_ack = a_rst & accept & grant1 & rs1_valid;
    end

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            ex_valid <= 1'b0;
            ex_uop   <= NOP;
            ex_pc    <= 16'd0;
            ex_data  <= 16'd0;
            ex_src   <= 1'b0;
        end else if (accept) begin
            if (rs0_ack) begin
                ex_valid <= 1'b1;
                ex_uop   <= rs0_uop;
                ex_pc    <= rs0_pc;
                ex_data  <= rs0_data;
                ex_src   <= 1'b0;
            end else if (rs1_ack) begin
                ex_valid <= 1'b1;
                ex_uop   <= rs1_uop;
                ex_pc    <= rs1_pc;
                ex_data  <= rs1_data;
                ex_src   <= 1'b1;
            end else begin
                // pc/data/src keep the last issued values for debug visibility.
                ex_valid <= 1'b0;
                ex_uop   <= NOP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky timeout flag; a set in the same cycle as a clear wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            err_timeout <= 1'b0;
        end else if (timeout_fire) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_issue_arbiter.sv
module tb_ex_issue_arbiter;

    localparam logic [19:0] NOP = 20'b0000_0000_1111_00_000_000;
    localparam int          LT  = 4;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        rs0_valid, rs0_last, rs0_ack;
    logic [19:0] rs0_uop;
    logic [15:0] rs0_pc, rs0_data;
    logic        rs1_valid, rs1_last, rs1_ack;
    logic [19:0] rs1_uop;
    logic [15:0] rs1_pc, rs1_data;
    logic        ex_ready, ex_valid, ex_src, err_timeout, err_clr;
    logic [19:0] ex_uop;
    logic [15:0] ex_pc, ex_data;

    ex_issue_arbiter #(.NOP(NOP), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .a_rst(a_rst),
        .rs0_valid(rs0_valid), .rs0_uop(rs0_uop), .rs0_last(rs0_last),
        .rs0_pc(rs0_pc), .rs0_data(rs0_data), .rs0_ack(rs0_ack),
        .rs1_valid(rs1_valid), .rs1_uop(rs1_uop), .rs1_last(rs1_last),
        .rs1_pc(rs1_pc), .rs1_data(rs1_data), .rs1_ack(rs1_ack),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_uop(ex_uop),
        .ex_pc(ex_pc), .ex_data(ex_data), .ex_src(ex_src),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_rst = 1'b0;
        cyc();
        cyc();
        a_rst = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks which station (if any) owns the unit, whose turn it is, how long
    // the owner has been silent, and what the output stage should hold.
    int          m_owner;   // -1: none
    int          m_rr;
    int          m_idle;
    bit          m_vld, m_src, m_err;
    logic [19:0] m_uop;
    logic [15:0] m_pc, m_data;

    function automatic void model_reset();
        m_owner = -1; m_rr = 0; m_idle = 0;
        m_vld = 0; m_src = 0; m_err = 0;
        m_uop = NOP; m_pc = 16'd0; m_data = 16'd0;
    endfunction

    function automatic bit st_valid(int n);
        return (n == 0) ? rs0_valid : rs1_valid;
    endfunction

    function automatic int model_ack();
        int cand = -1;
        if (m_owner < 0) begin
            if (rs0_valid && rs1_valid) cand = m_rr;
            else if (rs0_valid)         cand = 0;
            else if (rs1_valid)         cand = 1;
        end else if (st_valid(m_owner)) begin
            cand = m_owner;
        end
        return (ex_ready || !m_vld) ? cand : -1;
    endfunction

    function automatic void model_update(int ea);
        bit set_err = 0;
        if (ea >= 0) begin
            m_vld  = 1;
            m_src  = ea[0];
            m_uop  = (ea == 0) ? rs0_uop  : rs1_uop;
            m_pc   = (ea == 0) ? rs0_pc   : rs1_pc;
            m_data = (ea == 0) ? rs0_data : rs1_data;
            if ((ea == 0) ? rs0_last : rs1_last) begin
                m_owner = -1;
                m_rr    = 1 - ea;
            end else begin
                m_owner = ea;
            end
            m_idle = 0;
        end else begin
            if (ex_ready || !m_vld) begin
                m_vld = 0;
                m_uop = NOP;
            end
            if (m_owner >= 0) begin
                if (!st_valid(m_owner)) begin
                    m_idle++;
                    if (m_idle == LT) begin
                        m_rr    = 1 - m_owner;
                        m_owner = -1;
                        m_idle  = 0;
                        set_err = 1;
                    end
                end
            end else begin
                m_idle = 0;
            end
        end
        if (set_err) m_err = 1;
        else if (err_clr) m_err = 0;
    endfunction

    task automatic step();
        int ea;
        #1;
        ea = model_ack();
        chk("rnd_rs0_ack", rs0_ack, ea == 0);
        chk("rnd_rs1_ack", rs1_ack, ea == 1);
        cyc();
        model_update(ea);
        chk("rnd_ex_valid", ex_valid, m_vld);
        chk("rnd_ex_uop", ex_uop, m_uop);
        chk("rnd_ex_pc", ex_pc, m_pc);
        chk("rnd_ex_data", ex_data, m_data);
        chk("rnd_ex_src", ex_src, m_src);
        chk("rnd_err", err_timeout, m_err);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v0, l0, v1, l1, rdy;
        bit a0, a1;
        bit vld;
        int row;   // row whose uop is loaded this cycle, -1 if none
        bit src;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(bit v0, bit l0, bit v1, bit l1, bit rdy,
                                bit a0, bit a1, bit vld, int row, bit src);
        vec_t t;
        t.v0 = v0; t.l0 = l0; t.v1 = v1; t.l1 = l1; t.rdy = rdy;
        t.a0 = a0; t.a1 = a1; t.vld = vld; t.row = row; t.src = src;
        return t;
    endfunction

    initial begin
        int          cur_row;
        bit          cur_src;
        logic [19:0] eu;
        logic [15:0] epc, edat;
        int          pv0, pv1, prdy, mode;

        //               v0 l0 v1 l1 rdy a0 a1 vld row src
        tbl[0]  = mk(1, 1, 1, 1, 1, 1, 0, 1,  0, 0);   // round robin
        tbl[1]  = mk(1, 1, 1, 1, 1, 0, 1, 1,  1, 1);
        tbl[2]  = mk(1, 1, 1, 1, 1, 1, 0, 1,  2, 0);
        tbl[3]  = mk(1, 1, 1, 1, 1, 0, 1, 1,  3, 1);
        tbl[4]  = mk(1, 0, 1, 1, 1, 1, 0, 1,  4, 0);   // rs0 3-uop lock
        tbl[5]  = mk(1, 0, 1, 1, 1, 1, 0, 1,  5, 0);
        tbl[6]  = mk(1, 1, 1, 1, 1, 1, 0, 1,  6, 0);
        tbl[7]  = mk(0, 0, 1, 1, 1, 0, 1, 1,  7, 1);   // rs1 gets its turn
        tbl[8]  = mk(1, 0, 1, 0, 1, 1, 0, 1,  8, 0);   // lock with a gap
        tbl[9]  = mk(0, 0, 1, 0, 1, 0, 0, 0, -1, 0);
        tbl[10] = mk(1, 1, 1, 0, 1, 1, 0, 1, 10, 0);
        tbl[11] = mk(1, 1, 1, 1, 1, 0, 1, 1, 11, 1);
        tbl[12] = mk(1, 1, 1, 1, 0, 0, 0, 1, -1, 0);   // backpressure hold
        tbl[13] = mk(1, 1, 1, 1, 0, 0, 0, 1, -1, 0);
        tbl[14] = mk(1, 1, 1, 1, 1, 1, 0, 1, 14, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, -1, 0);
        tbl[16] = mk(0, 0, 1, 1, 1, 0, 1, 1, 16, 1);
        tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, 0, -1, 0);
        tbl[18] = mk(1, 1, 0, 0, 0, 1, 0, 1, 18, 0);   // empty stage accepts
        tbl[19] = mk(1, 1, 0, 0, 0, 0, 0, 1, -1, 0);

        a_rst = 1'b0;
        rs0_valid = 1; rs0_last = 1; rs0_uop = 20'h11111; rs0_pc = 16'h1234; rs0_data = 16'h5678;
        rs1_valid = 1; rs1_last = 1; rs1_uop = 20'h22222; rs1_pc = 16'h4321; rs1_data = 16'h8765;
        ex_ready = 1; err_clr = 0;

        // ---- reset values ----
        #2;
        chk("rst_rs0_ack", rs0_ack, 0);
        chk("rst_rs1_ack", rs1_ack, 0);
        cyc();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_uop", ex_uop, NOP);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_data", ex_data, 0);
        chk("rst_ex_src", ex_src, 0);
        chk("rst_err", err_timeout, 0);
        a_rst = 1'b1;

        // ---- table ----
        cur_row = -1;
        cur_src = 0;
        for (int i = 0; i < 20; i++) begin
            rs0_valid = tbl[i].v0; rs0_last = tbl[i].l0;
            rs1_valid = tbl[i].v1; rs1_last = tbl[i].l1;
            ex_ready  = tbl[i].rdy;
            rs0_uop  = 20'h10000 + 20'(i); rs1_uop  = 20'h20000 + 20'(i);
            rs0_pc   = 16'h0A00 + 16'(i);  rs1_pc   = 16'h1B00 + 16'(i);
            rs0_data = 16'h5000 + 16'(i);  rs1_data = 16'h6000 + 16'(i);
            #1;
            chk("tbl_rs0_ack", rs0_ack, tbl[i].a0);
            chk("tbl_rs1_ack", rs1_ack, tbl[i].a1);
            cyc();
            if (tbl[i].row >= 0) begin
                cur_row = tbl[i].row;
                cur_src = tbl[i].src;
            end
            eu   = !tbl[i].vld ? NOP : ((cur_src ? 20'h20000 : 20'h10000) + 20'(cur_row));
            epc  = (cur_row < 0) ? 16'd0 : ((cur_src ? 16'h1B00 : 16'h0A00) + 16'(cur_row));
            edat = (cur_row < 0) ? 16'd0 : ((cur_src ? 16'h6000 : 16'h5000) + 16'(cur_row));
            chk("tbl_ex_valid", ex_valid, tbl[i].vld);
            chk("tbl_ex_uop", ex_uop, eu);
            chk("tbl_ex_pc", ex_pc, epc);
            chk("tbl_ex_data", ex_data, edat);
            chk("tbl_ex_src", ex_src, (cur_row < 0) ? 1'b0 : cur_src);
        end

        // ---- timeout ----
        ex_ready = 1; err_clr = 0;
        rs0_valid = 0; rs1_valid = 0;
        do_reset();
        rs0_valid = 1; rs0_last = 0; rs0_uop = 20'h0C0DE;
        #1 chk("to_first_ack", rs0_ack, 1);
        cyc();
        rs0_valid = 0;
        rs1_valid = 1; rs1_last = 1; rs1_uop = 20'h0BEEF;
        for (int k = 1; k <= LT; k++) begin
            #1 chk("to_lock_hold", rs1_ack, 0);
            cyc();
            chk("to_err", err_timeout, k == LT);
        end
        #1 chk("to_rs1_granted", rs1_ack, 1);
        cyc();
        chk("to_rs1_uop", ex_uop, 20'h0BEEF);
        chk("to_rs1_src", ex_src, 1);
        chk("to_err_sticky", err_timeout, 1);
        rs1_valid = 0; err_clr = 1;
        cyc();
        chk("to_err_clr", err_timeout, 0);
        err_clr = 0;

        // ---- set/clear collision ----
        rs0_valid = 1; rs0_last = 0; rs0_uop = 20'h0D00D;
        #1 chk("col_ack", rs0_ack, 1);
        cyc();
        rs0_valid = 0; err_clr = 1;
        for (int k = 1; k <= LT; k++) begin
            cyc();
            chk("col_err", err_timeout, k == LT);
        end
        err_clr = 0;

        // ---- reset mid-lock (err is set going in) ----
        rs0_valid = 1; rs0_last = 0; rs0_uop = 20'hA0A0A; rs0_pc = 16'hAAAA;
        #1 chk("rml_ack_a", rs0_ack, 1);
        cyc();
        chk("rml_ex_uop_a", ex_uop, 20'hA0A0A);
        #2 a_rst = 1'b0;
        #1;
        chk("rml_ex_valid", ex_valid, 0);
        chk("rml_ex_uop", ex_uop, NOP);
        chk("rml_ex_pc", ex_pc, 0);
        chk("rml_err", err_timeout, 0);
        chk("rml_rs0_ack", rs0_ack, 0);
        cyc();
        a_rst = 1'b1;
        rs0_valid = 0;
        rs1_valid = 1; rs1_last = 1; rs1_uop = 20'h0F00F;
        #1 chk("rml_rs1_ack", rs1_ack, 1);
        cyc();
        chk("rml_rs1_src", ex_src, 1);
        chk("rml_rs1_uop", ex_uop, 20'h0F00F);

        // ---- randomized against the model ----
        rs0_valid = 0; rs1_valid = 0; err_clr = 0; ex_ready = 1;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            mode = (c / 250) % 4;
            case (mode)
                0:       begin pv0 = 75; pv1 = 75; prdy = 70;  end
                1:       begin pv0 = 20; pv1 = 80; prdy = 70;  end
                2:       begin pv0 = 80; pv1 = 20; prdy = 60;  end
                default: begin pv0 = 95; pv1 = 95; prdy = 100; end
            endcase
            rs0_valid = ($urandom_range(0, 99) < pv0);
            rs1_valid = ($urandom_range(0, 99) < pv1);
            rs0_last  = ($urandom_range(0, 99) < 35);
            rs1_last  = ($urandom_range(0, 99) < 35);
            rs0_uop   = 20'($urandom());
            rs1_uop   = 20'($urandom());
            rs0_pc    = 16'($urandom());
            rs1_pc    = 16'($urandom());
            rs0_data  = 16'($urandom());
            rs1_data  = 16'($urandom());
            ex_ready  = ($urandom_range(0, 99) < prdy);
            err_clr   = ($urandom_range(0, 99) < 5);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
